uart_tx_cfg: RTL and testbench

Parametrised UART transmitter. Supports configurable data width, runtime baud divisor, runtime parity (none/even/odd) and runtime 1 or 2 stop bits. Frames are accepted through a valid/ready handshake, so back-to-back frames need no idle gap. Sits between the USB-side byte stream and the serial pin, and is used in the UART simulation bench as the stimulus driver.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_cfg_if.sv | 22 ++
 rtl/uart_baud_tick.sv | 49 ++++
 rtl/uart_tx_cfg.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by the transmitter and the future receiver.
package uart_pkg;

  localparam int DIV_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  // Mode 3 is deliberately treated the same as PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Frame handshake between a byte source and the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_W = 8
) ();

  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_ready;

  modport master (
    output i_valid,
    output i_data,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_data,
    output o_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..div and flags the last cycle of each bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             i_restart,
  input  logic             i_enable,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_bit_end,
  output logic             o_near_end
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cnt_inc;
  logic             at_end;

  assign cnt_inc   = cnt_q + DIV_W'(1);
  assign at_end    = (cnt_q == div_q);
  assign o_bit_end = i_enable && at_end;

  // True when the following cycle will be the last cycle of a bit.
  assign o_near_end = at_end ? (div_q == '0) : (cnt_inc == div_q);

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (i_restart) begin
      div_d = i_div;
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = at_end ? '0 : cnt_inc;
    end
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime divisor, parity and stop-bit count; frames
// arrive over a valid/ready handshake and may run back to back.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = DIV_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] i_div,
  input  logic [1:0]       i_parity,
  input  logic             i_stop2,
  uart_tx_cfg_if.slave     bus,
  output logic             o_tx_pin,
  output logic             o_busy,
  output logic             o_done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        par_q, par_d;
  logic              stop2_q, stop2_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_cnt_q, stop_cnt_d;

  logic              accept;
  logic              load;
  logic              bit_end;
  logic              near_end;
  logic [IDX_W-1:0]  idx_inc;

  assign accept  = bus.i_valid && ready_q;
  assign idx_inc = idx_q + IDX_W'(1);

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud (
    .i_clk      (i_clk),
    .reset      (reset),
    .i_restart  (load),
    .i_enable   (state_q != IDLE),
    .i_div      (i_div),
    .o_bit_end  (bit_end),
    .o_near_end (near_end)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    data_d     = data_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;
    load       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_inc;
            tx_d  = data_q[idx_inc];
          end else if (parity_enabled(par_q)) begin
            state_d = PARITY;
            tx_d    = parity_bit(par_q, ^data_q);
          end else begin
            state_d    = STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (accept) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A new frame snapshots payload and config; the divisor goes to the tick counter.
    if (load) begin
      state_d    = START;
      tx_d       = 1'b0;
      data_d     = bus.i_data;
      par_d      = i_parity;
      stop2_d    = i_stop2;
      idx_d      = '0;
      stop_cnt_d = 1'b0;
    end

    busy_d  = (state_d != IDLE);
    // Ready is registered one cycle early so it is high exactly in the last stop cycle.
    ready_d = (state_d == IDLE) ||
              ((state_d == STOP) && (!stop2_q || stop_cnt_d) && near_end);
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      par_q      <= '0;
      stop2_q    <= 1'b0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_q     <= data_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  assign o_tx_pin    = tx_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign bus.o_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: stimulus pushes expected line waveforms,
// a negedge monitor pops and checks them cycle by cycle.
module tb_uart_tx_cfg;

  logic        i_clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] i_div = '0;
  logic [1:0]  i_parity = '0;
  logic        i_stop2 = 1'b0;
  logic        o_tx_pin;
  logic        o_busy;
  logic        o_done;

  uart_tx_cfg_if #(.DATA_W(8)) bus ();

  uart_tx_cfg #(
    .DATA_W (8),
    .DIV_W  (16)
  ) dut (
    .i_clk    (i_clk),
    .reset    (reset),
    .i_div    (i_div),
    .i_parity (i_parity),
    .i_stop2  (i_stop2),
    .bus      (bus),
    .o_tx_pin (o_tx_pin),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [11:0] bits;
    int          n;
    int          bc;
    logic [7:0]  data;
  } frame_t;

  frame_t sb[$];
  frame_t cur;
  int     n_checks = 0;
  int     n_fail = 0;
  logic   active = 1'b0;
  logic   done_exp = 1'b0;
  int     cyc = 0;
  int     bit_i = 0;
  int     total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares the line, ready, busy and done against the popped frame.
  always @(negedge i_clk) begin
    if (!reset) begin
      active   = 1'b0;
      done_exp = 1'b0;
      sb.delete();
      check("reset_tx", o_tx_pin, 1);
      check("reset_ready", bus.o_ready, 1);
      check("reset_busy", o_busy, 0);
      check("reset_done", o_done, 0);
    end else begin
      if (done_exp || o_done) check("done_pulse", o_done, done_exp);
      done_exp = 1'b0;
      if (!active) begin
        if (o_tx_pin == 1'b0) begin
          check("start_has_frame", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            cur    = sb.pop_front();
            active = 1'b1;
            cyc    = 0;
            total  = cur.n * cur.bc;
          end
        end else begin
          check("idle_ready", bus.o_ready, 1);
          check("idle_busy", o_busy, 0);
        end
      end
      if (active) begin
        bit_i = cyc / cur.bc;
        check($sformatf("frame_%02h_bit%0d_cyc%0d", cur.data, bit_i, cyc), o_tx_pin, cur.bits[bit_i]);
        check($sformatf("frame_%02h_busy", cur.data), o_busy, 1);
        check($sformatf("frame_%02h_ready_cyc%0d", cur.data, cyc), bus.o_ready, (cyc == total - 1));
        if (cyc == total - 1) begin
          active   = 1'b0;
          done_exp = 1'b1;
        end else begin
          cyc++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic [15:0] div,
                               input logic [1:0] par, input logic s2, input logic exp_par);
    frame_t f;
    int     waited = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    i_div       = div;
    i_parity    = par;
    i_stop2     = s2;
    while (bus.o_ready !== 1'b1 && waited < 2000) begin
      @(negedge i_clk);
      waited++;
    end
    if (bus.o_ready !== 1'b1) begin
      check("ready_timeout", bus.o_ready, 1);
      bus.i_valid = 1'b0;
      return;
    end
    f.bits = '0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1 + i] = d[i];
    f.n = 9;
    if (par == 2'd1 || par == 2'd2) begin
      f.bits[f.n] = exp_par;
      f.n++;
    end
    f.bits[f.n] = 1'b1;
    f.n++;
    if (s2) begin
      f.bits[f.n] = 1'b1;
      f.n++;
    end
    f.bc   = int'(div) + 1;
    f.data = d;
    sb.push_back(f);
    @(negedge i_clk);
  endtask

  task automatic releaseValid();
    bus.i_valid = 1'b0;
  endtask

  task automatic checkOutput();
    int waited = 0;
    while ((sb.size() != 0 || active || o_busy) && waited < 5000) begin
      @(negedge i_clk);
      waited++;
    end
    check("drain_timeout", (sb.size() == 0 && !active && !o_busy), 1);
    repeat (2) @(negedge i_clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    repeat (3) @(negedge i_clk);
    reset = 1'b1;
    @(negedge i_clk);

    // 0xA5, div 3, no parity, 1 stop: 40-cycle frame
    applyStimulus(8'hA5, 16'd3, 2'd0, 1'b0, 1'b0);
    releaseValid();
    checkOutput();

    // 0x07, div 0: even parity bit 1, odd parity bit 0
    applyStimulus(8'h07, 16'd0, 2'd1, 1'b0, 1'b1);
    releaseValid();
    checkOutput();
    applyStimulus(8'h07, 16'd0, 2'd2, 1'b0, 1'b0);
    releaseValid();
    checkOutput();

    // 0xFF, div 1, two stop bits; stray valid mid-frame must be ignored
    applyStimulus(8'hFF, 16'd1, 2'd0, 1'b1, 1'b0);
    releaseValid();
    repeat (5) @(negedge i_clk);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h00;
    repeat (3) @(negedge i_clk);
    releaseValid();
    checkOutput();

    // div 0 with two stop bits and odd parity (0x81 -> parity 1)
    applyStimulus(8'h81, 16'd0, 2'd2, 1'b1, 1'b1);
    releaseValid();
    checkOutput();

    // back to back: 0x12 (even par 0) then 0x34 (even par 1), valid held
    applyStimulus(8'h12, 16'd2, 2'd1, 1'b0, 1'b0);
    applyStimulus(8'h34, 16'd2, 2'd1, 1'b0, 1'b1);
    releaseValid();
    checkOutput();

    // config change mid-frame only affects the next frame (0xC3 odd par 1)
    applyStimulus(8'h5A, 16'd3, 2'd0, 1'b0, 1'b0);
    releaseValid();
    repeat (10) @(negedge i_clk);
    i_div    = 16'd7;
    i_parity = 2'd2;
    i_stop2  = 1'b1;
    applyStimulus(8'hC3, 16'd7, 2'd2, 1'b0, 1'b1);
    releaseValid();
    checkOutput();

    // reset during data bit 3 of 0x96 (bit 3 = 0)
    applyStimulus(8'h96, 16'd3, 2'd0, 1'b0, 1'b0);
    releaseValid();
    repeat (17) @(negedge i_clk);
    check("pre_reset_bit3", o_tx_pin, 0);
    #1 reset = 1'b0;
    #1;
    check("async_reset_tx", o_tx_pin, 1);
    check("async_reset_busy", o_busy, 0);
    check("async_reset_ready", bus.o_ready, 1);
    check("async_reset_done", o_done, 0);
    repeat (3) @(negedge i_clk);
    reset = 1'b1;
    repeat (2) @(negedge i_clk);

    // after reset: parity mode 3 acts as none, two stop bits
    applyStimulus(8'h3C, 16'd1, 2'd3, 1'b1, 1'b0);
    releaseValid();
    checkOutput();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
